// File: rtl/fir_job_ctrl.sv
// fir_job_ctrl: launches one FIR engine per job, arbitrates the shared sample memory port and times the run
module fir_job_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sel_pipelined,
  input  logic [ADDR_W-1:0] in_base,
  input  logic [ADDR_W-1:0] out_base,
  input  logic [ADDR_W-1:0] sample_count,
  output logic [1:0]        eng_start,
  output logic [1:0]        eng_abort,
  output logic [ADDR_W-1:0] eng_in_base,
  output logic [ADDR_W-1:0] eng_out_base,
  output logic [ADDR_W-1:0] eng_count,
  input  logic [1:0]        eng_done,
  input  logic [ADDR_W-1:0] np_addr,
  input  logic              np_we,
  input  logic [DATA_W-1:0] np_wdata,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic              p_we,
  input  logic [DATA_W-1:0] p_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  cycle_total,
  output logic              last_sel,
  output logic              err_timeout
);
  typedef enum logic [1:0] {IDLE, LAUNCH, RUN} state_t;
  state_t state_q, state_d;
  logic owner_q, owner_d, done_q, done_d, last_sel_q, last_sel_d, err_q, err_d;
  logic [ADDR_W-1:0] in_base_q, in_base_d, out_base_q, out_base_d, count_q, count_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, total_q, total_d, cnt_inc;
  logic hit, expire, act;
  always_comb begin
    cnt_inc = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
    hit = eng_done[owner_q];
    expire = cnt_inc >= CNT_W'(TIMEOUT);
    state_d = state_q;
    owner_d = owner_q;
    done_d = done_q;
    last_sel_d = last_sel_q;
    err_d = err_q;
    in_base_d = in_base_q;
    out_base_d = out_base_q;
    count_d = count_q;
    cnt_d = cnt_q;
    total_d = total_q;
    eng_start = '0;
    eng_abort = '0;
    case (state_q)
      IDLE: if (start) begin
        done_d = sample_count == '0;
        err_d = 1'b0;
        if (sample_count != '0) begin
          owner_d = sel_pipelined;
          in_base_d = in_base;
          out_base_d = out_base;
          count_d = sample_count;
          state_d = LAUNCH;
        end else begin
          total_d = '0;
          last_sel_d = sel_pipelined;
        end
      end
      LAUNCH: begin
        eng_start[owner_q] = 1'b1;
        cnt_d = CNT_W'(1);
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_inc;
        if (hit || expire) begin
          eng_abort[owner_q] = !hit;
          err_d = !hit;
          done_d = 1'b1;
          last_sel_d = owner_q;
          total_d = hit ? cnt_inc : CNT_W'(TIMEOUT);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      done_q <= 1'b0;
      last_sel_q <= 1'b0;
      err_q <= 1'b0;
      in_base_q <= '0;
      out_base_q <= '0;
      count_q <= '0;
      cnt_q <= '0;
      total_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      done_q <= done_d;
      last_sel_q <= last_sel_d;
      err_q <= err_d;
      in_base_q <= in_base_d;
      out_base_q <= out_base_d;
      count_q <= count_d;
      cnt_q <= cnt_d;
      total_q <= total_d;
    end
  end
  assign act = state_q != IDLE;
  assign busy = act;
  assign mem_addr = act ? (owner_q ? p_addr : np_addr) : '0;
  assign mem_we = act && (owner_q ? p_we : np_we);
  assign mem_wdata = act ? (owner_q ? p_wdata : np_wdata) : '0;
  assign eng_in_base = in_base_q;
  assign eng_out_base = out_base_q;
  assign eng_count = count_q;
  assign done = done_q;
  assign cycle_total = total_q;
  assign last_sel = last_sel_q;
  assign err_timeout = err_q;
endmodule

// File: doc/fir_job_ctrl.md
Name: fir_job_ctrl

Overview:
- Job controller and memory-port arbiter in front of the two FIR engines, non-pipelined (engine 0) and pipelined (engine 1).
- Accepts one filter job from the top level: engine select, input base, output base and sample count.
- Launches the selected engine, grants it exclusive use of the shared sample memory port, and measures run length in clock cycles.
- Reports done, busy, cycle total and timeout error to fir_top.

Parameters:
ADDR_W, 10, sample memory address width
DATA_W, 8, sample width (signed two's complement)
CNT_W, 32, cycle counter width
TIMEOUT, 4096, maximum cycles per job before abort

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  job request, sampled in IDLE only
sel_pipelined  in  1  0 = engine 0, 1 = engine 1; latched with start
in_base  in  ADDR_W  first input sample address; latched with start
out_base  in  ADDR_W  first output address; latched with start
sample_count  in  ADDR_W  samples to process; latched with start
eng_start  out  2  one-hot, one-cycle launch pulse to the owning engine
eng_abort  out  2  one-hot, one-cycle abort pulse on timeout
eng_in_base  out  ADDR_W  latched in_base, broadcast to both engines
eng_out_base  out  ADDR_W  latched out_base, broadcast
eng_count  out  ADDR_W  latched sample_count, broadcast
eng_done  in  2  per-engine completion pulses
np_addr, np_we, np_wdata  in  ADDR_W/1/DATA_W  engine 0 memory request
p_addr, p_we, p_wdata  in  ADDR_W/1/DATA_W  engine 1 memory request
mem_addr  out  ADDR_W  shared memory address
mem_we  out  1  shared memory write enable
mem_wdata  out  DATA_W  shared memory write data
busy  out  1  high in LAUNCH and RUN
done  out  1  level; set at job end, cleared when the next start is accepted
cycle_total  out  CNT_W  cycles taken by the last job
last_sel  out  1  engine used by the last job
err_timeout  out  1  last job aborted; cleared when the next start is accepted

Behaviour:
- Reset: state IDLE; all outputs and latched registers 0.
- FSM states: IDLE, LAUNCH, RUN.
- IDLE, start high, sample_count != 0:
  - latch config and owner = sel_pipelined.
  - clear done and err_timeout.
  - next state LAUNCH.
- IDLE, start high, sample_count == 0:
  - next cycle: done = 1, cycle_total = 0, err_timeout = 0, last_sel = sel_pipelined.
  - no eng_start pulse; stay IDLE.
- LAUNCH (exactly one cycle):
  - eng_start[owner] = 1; busy = 1.
  - cycle counter counts this cycle as 1.
  - next state RUN.
- RUN: counter increments every cycle.
  - On the first cycle eng_done[owner] is high: cycle_total = cycles from the LAUNCH cycle through this cycle inclusive; done = 1; last_sel = owner; next state IDLE.
  - Example: eng_done 3 cycles after LAUNCH gives cycle_total = 4.
- Timeout: in RUN, if the count reaches TIMEOUT with no eng_done[owner]:
  - eng_abort[owner] pulses one cycle.
  - err_timeout = 1, done = 1, cycle_total = TIMEOUT.
  - next state IDLE.
- eng_done from the non-owner engine is ignored in all states. eng_done[owner] while in IDLE is ignored.
- start while busy is ignored and has no effect on the running job or on latched config.
- eng_done[owner] in the same cycle the count reaches TIMEOUT: completion wins, err_timeout = 0.
- Memory mux (combinational on registered owner/state):
  - LAUNCH/RUN: mem_* = owner engine's request; the other engine's we is blocked.
  - IDLE: mem_we = 0, mem_addr = 0, mem_wdata = 0.
- Counter saturates at its all-ones value; it never wraps.
- rst mid-job: state returns to IDLE the next edge; all outputs cleared; no eng_abort pulse (engines share rst).
- Latency: start sampled at edge T; eng_start and busy high in cycle T+1.

Test Plan:
- Reset: hold rst 2 cycles with start = 1 -> all outputs 0, no eng_start pulse, mem_we = 0.
- Engine 0 job: start with sel = 0, in_base 0, out_base 512, count 100; model asserts eng_done[0] 305 cycles after eng_start -> eng_start = 01 for one cycle, mem_* tracks np_*, p_we = 1 is blocked, cycle_total = 306, done = 1, last_sel = 0, busy low after done.
- Engine 1 job: start with sel = 1, same bases; eng_done[1] 103 cycles after launch -> cycle_total = 104, mem_* tracks p_*, previous done cleared on the accept cycle.
- Interference: during an engine 0 run, pulse start with sel = 1 and pulse eng_done[1] -> no effect; later eng_done[0] gives the correct total; latched eng_count unchanged.
- Zero count: start with count 0 -> done next cycle, cycle_total = 0, busy never high, eng_start never pulses.
- Timeout (TIMEOUT = 16): engine never completes -> eng_abort[owner] pulses once, err_timeout = 1, done = 1, cycle_total = 16, return to IDLE. Repeat with eng_done on cycle 16 -> err_timeout = 0.
